// File: rtl/dilated_tap_cache_if.sv
// Sample/tap bus between the activation source, dilated_tap_cache and the dot product stage.
// Handshake: `in` is taken on any cycle with in_v && in_rdy. An in_v while in_rdy is low drops the sample and raises ovf.
// out_v is a single-cycle pulse that qualifies `a`, and `a` stays stable until the next pulse.
interface dilated_tap_cache_if #(
  parameter int W = 16
);
  logic signed [W-1:0] in;
  logic                in_v;
  logic                in_rdy;
  logic signed [W-1:0] a [0:3];
  logic                out_v;
  logic                ovf;

  modport master (output in, in_v, input in_rdy, a, out_v, ovf);
  modport slave  (input in, in_v, output in_rdy, a, out_v, ovf);
endinterface

// File: rtl/dilated_tap_cache.sv
// Ring buffer of the last 3*DILATION+1 samples. Each emit presents the taps x[t-3D], x[t-2D], x[t-D], x[t] and holds them for HOLD_CYCLES.
// Optional causal zero padding: define DILATED_TAP_CACHE_ZERO_PAD_EN.
module dilated_tap_cache #(
  parameter int W           = 16,
  parameter int DILATION    = 2,
  parameter int HOLD_CYCLES = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  dilated_tap_cache_if.slave bus,
  output logic [1:0]        dbg_state
);
  localparam int N  = 3 * DILATION + 1;
  localparam int PW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [PW-1:0]       wr_ptr;
  logic [CW-1:0]       fill_cnt, fill_inc;
  logic                out_v_q, ovf_q, emit, accept;
  logic signed [W-1:0] mem [0:N-1];
  logic signed [W-1:0] a_q [0:3];
  logic signed [W-1:0] tap [0:3];
  logic [PW:0]         rd_sum  [1:3];
  logic [PW-1:0]       rd_addr [1:3];

  assign bus.in_rdy = (state_q != HOLD);
  assign bus.out_v  = out_v_q;
  assign bus.ovf    = ovf_q;
  assign bus.a      = a_q;
  assign dbg_state  = state_q;

  assign accept   = bus.in_v && bus.in_rdy;
  assign fill_inc = (fill_cnt == CW'(N)) ? fill_cnt : fill_cnt + CW'(1);

  // Read-before-write tap gather. The k=3 address is wr_ptr+1 and never aliases the slot being written.
  always_comb begin
    tap[3] = bus.in;
    for (int k = 1; k <= 3; k++) begin
      rd_sum[k] = {1'b0, wr_ptr} + (PW+1)'(N - k * DILATION);
      if (rd_sum[k] >= (PW+1)'(N)) rd_addr[k] = PW'(rd_sum[k] - (PW+1)'(N));
      else                         rd_addr[k] = rd_sum[k][PW-1:0];
      tap[3-k] = mem[rd_addr[k]];
`ifdef DILATED_TAP_CACHE_ZERO_PAD_EN
      // Tap k holds real data only once at least k*D samples precede the current one.
      if (k * DILATION > int'(fill_cnt)) tap[3-k] = '0;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    emit    = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
`ifdef DILATED_TAP_CACHE_ZERO_PAD_EN
          emit = 1'b1;
`else
          emit = (fill_inc == CW'(N));
`endif
        end
      end
      RUN:  emit = accept;
      HOLD: begin
        if (hold_q == '0) state_d = RUN;
        else              hold_d  = hold_q - HW'(1);
      end
      default: state_d = FILL;
    endcase
    // The out_v cycle is the first of the HOLD_CYCLES frozen cycles.
    if (emit) begin
      state_d = HOLD;
      hold_d  = HW'(HOLD_CYCLES - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      hold_q   <= '0;
      wr_ptr   <= '0;
      fill_cnt <= '0;
      out_v_q  <= 1'b0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < 4; i++) a_q[i] <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      out_v_q <= emit;
      if (bus.in_v && !bus.in_rdy) ovf_q <= 1'b1;
      if (accept) begin
        wr_ptr   <= (wr_ptr == PW'(N - 1)) ? '0 : wr_ptr + PW'(1);
        fill_cnt <= fill_inc;
      end
      if (emit) begin
        for (int i = 0; i < 4; i++) a_q[i] <= tap[i];
      end
    end
  end

  // Buffer contents are masked by the fill logic, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= bus.in;
  end
endmodule

// File: tb/tb_dilated_tap_cache.sv
// Directed bench for dilated_tap_cache (D=2, N=7, HOLD_CYCLES=5).
// It checks fill, run, hold window, drop/ovf, signed extremes and reset during HOLD.
module tb_dilated_tap_cache;
  localparam int W  = 16;
  localparam int D  = 2;
  localparam int HC = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [4*W-1:0] a_flat;
  logic signed [W-1:0] pat [0:2];

  dilated_tap_cache_if #(.W(W)) bus ();

  dilated_tap_cache #(.W(W), .DILATION(D), .HOLD_CYCLES(HC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  assign a_flat = {bus.a[0], bus.a[1], bus.a[2], bus.a[3]};

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic signed [W-1:0] v);
    bus.in   = v;
    bus.in_v = 1'b1;
    step(1);
    bus.in_v = 1'b0;
  endtask

`ifdef DILATED_TAP_CACHE_ZERO_PAD_EN
  function automatic logic [W-1:0] pad_tap(input int i, input int k);
    return (k * D > i - 1) ? '0 : W'(i - k * D);
  endfunction
`endif

  task automatic test_reset;
    bus.in   = '0;
    bus.in_v = 1'b0;
    rst_n    = 1'b0;
    step(2);
    n_cmp++; if (a_flat !== '0) begin n_bad++; $display("FAIL reset_a: got %h expected 0", a_flat); end
    n_cmp++; if (bus.out_v !== 1'b0) begin n_bad++; $display("FAIL reset_out_v: got %b expected 0", bus.out_v); end
    n_cmp++; if (bus.in_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_in_rdy: got %b expected 1", bus.in_rdy); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_fill;
    logic [4*W-1:0] exp;
    logic           exp_v;
    for (int i = 1; i <= 7; i++) begin
      send(W'(i));
`ifdef DILATED_TAP_CACHE_ZERO_PAD_EN
      exp_v = 1'b1;
      exp   = {pad_tap(i, 3), pad_tap(i, 2), pad_tap(i, 1), W'(i)};
`else
      exp_v = (i == 7);
      exp   = {W'(1), W'(3), W'(5), W'(7)};
`endif
      n_cmp++; if (bus.out_v !== exp_v) begin n_bad++; $display("FAIL fill_out_v[%0d]: got %b expected %b", i, bus.out_v, exp_v); end
      if (exp_v) begin
        n_cmp++; if (a_flat !== exp) begin n_bad++; $display("FAIL fill_taps[%0d]: got %h expected %h", i, a_flat, exp); end
        n_cmp++; if (bus.in_rdy !== 1'b0) begin n_bad++; $display("FAIL fill_hold_rdy[%0d]: got %b expected 0", i, bus.in_rdy); end
      end
      step(1);
      n_cmp++; if (bus.out_v !== 1'b0) begin n_bad++; $display("FAIL fill_pulse_width[%0d]: got %b expected 0", i, bus.out_v); end
      step(4);
    end
  endtask

  task automatic test_overflow;
    send(W'(8));
    n_cmp++; if (a_flat !== {W'(2), W'(4), W'(6), W'(8)}) begin n_bad++; $display("FAIL ovf_taps8: got %h expected %h", a_flat, {W'(2), W'(4), W'(6), W'(8)}); end
    step(1);
    bus.in   = W'(9);
    bus.in_v = 1'b1;
    n_cmp++; if (bus.in_rdy !== 1'b0) begin n_bad++; $display("FAIL ovf_in_rdy: got %b expected 0", bus.in_rdy); end
    step(1);
    bus.in_v = 1'b0;
    n_cmp++; if (bus.ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b expected 1", bus.ovf); end
    n_cmp++; if (bus.out_v !== 1'b0) begin n_bad++; $display("FAIL ovf_no_emit: got %b expected 0", bus.out_v); end
    n_cmp++; if (a_flat !== {W'(2), W'(4), W'(6), W'(8)}) begin n_bad++; $display("FAIL ovf_taps_held: got %h expected %h", a_flat, {W'(2), W'(4), W'(6), W'(8)}); end
    step(3);
    send(W'(9));
    n_cmp++; if (bus.out_v !== 1'b1) begin n_bad++; $display("FAIL ovf_resend_v: got %b expected 1", bus.out_v); end
    n_cmp++; if (a_flat !== {W'(3), W'(5), W'(7), W'(9)}) begin n_bad++; $display("FAIL ovf_taps9: got %h expected %h", a_flat, {W'(3), W'(5), W'(7), W'(9)}); end
    step(5);
  endtask

  task automatic test_hold_window;
    int low_cnt;
    low_cnt = 0;
    send(W'(10));
    n_cmp++; if (a_flat !== {W'(4), W'(6), W'(8), W'(10)}) begin n_bad++; $display("FAIL hold_taps10: got %h expected %h", a_flat, {W'(4), W'(6), W'(8), W'(10)}); end
    for (int i = 0; i < 6; i++) begin
      if (bus.in_rdy === 1'b0) low_cnt++;
      if (i < 5) step(1);
    end
    n_cmp++; if (low_cnt !== HC) begin n_bad++; $display("FAIL hold_len: got %0d expected %0d", low_cnt, HC); end
    n_cmp++; if (bus.in_rdy !== 1'b1) begin n_bad++; $display("FAIL hold_release: got %b expected 1", bus.in_rdy); end
  endtask

  task automatic test_run;
    logic [4*W-1:0] exp;
    for (int t = 11; t <= 19; t++) begin
      send(W'(t));
      exp = {W'(t - 6), W'(t - 4), W'(t - 2), W'(t)};
      n_cmp++; if (bus.out_v !== 1'b1) begin n_bad++; $display("FAIL run_out_v[%0d]: got %b expected 1", t, bus.out_v); end
      n_cmp++; if (a_flat !== exp) begin n_bad++; $display("FAIL run_taps[%0d]: got %h expected %h", t, a_flat, exp); end
      step(1);
      n_cmp++; if (bus.out_v !== 1'b0) begin n_bad++; $display("FAIL run_pulse_width[%0d]: got %b expected 0", t, bus.out_v); end
      n_cmp++; if (a_flat !== exp) begin n_bad++; $display("FAIL run_taps_held[%0d]: got %h expected %h", t, a_flat, exp); end
      step(4);
    end
  endtask

  task automatic test_reset_mid_hold;
    logic exp_v;
    send(W'(20));
    n_cmp++; if (a_flat !== {W'(14), W'(16), W'(18), W'(20)}) begin n_bad++; $display("FAIL mid_taps20: got %h expected %h", a_flat, {W'(14), W'(16), W'(18), W'(20)}); end
    step(1);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (a_flat !== '0) begin n_bad++; $display("FAIL mid_rst_a: got %h expected 0", a_flat); end
    n_cmp++; if (bus.in_rdy !== 1'b1) begin n_bad++; $display("FAIL mid_rst_in_rdy: got %b expected 1", bus.in_rdy); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ovf: got %b expected 0", bus.ovf); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL mid_rst_state: got %0d expected 0", dbg_state); end
    step(1);
    rst_n = 1'b1;
    step(1);
    for (int j = 1; j <= 6; j++) begin
      send(pat[(j - 1) % 3]);
`ifdef DILATED_TAP_CACHE_ZERO_PAD_EN
      exp_v = 1'b1;
`else
      exp_v = 1'b0;
`endif
      n_cmp++; if (bus.out_v !== exp_v) begin n_bad++; $display("FAIL neg_fill_v[%0d]: got %b expected %b", j, bus.out_v, exp_v); end
      step(5);
    end
    send(pat[0]);
    n_cmp++; if (bus.out_v !== 1'b1) begin n_bad++; $display("FAIL neg_emit7_v: got %b expected 1", bus.out_v); end
    n_cmp++; if (a_flat !== 64'h8000_7fff_ffff_8000) begin n_bad++; $display("FAIL neg_taps7: got %h expected %h", a_flat, 64'h8000_7fff_ffff_8000); end
    step(5);
    send(pat[1]);
    n_cmp++; if (a_flat !== 64'hffff_8000_7fff_ffff) begin n_bad++; $display("FAIL neg_taps8: got %h expected %h", a_flat, 64'hffff_8000_7fff_ffff); end
    step(5);
  endtask

  initial begin
    pat[0] = 16'sh8000;
    pat[1] = 16'shffff;
    pat[2] = 16'sh7fff;
    test_reset();
    test_fill();
    test_overflow();
    test_hold_window();
    test_run();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end
endmodule
